// File: rtl/dram_axi_burst_master.sv
// dram_axi_burst_master
// AXI4 burst master between the core-side memory port and the DRAM controller's AXI
// slave port. Each user command becomes one INCR burst of 1..256 beats. A command is
// rejected with no AXI traffic if it is misaligned or would cross a 4 KB page.
// Only one command is in flight at a time.
//
// Ports:
//   i_clk, i_rst_x           clock, synchronous active-low reset
//   i_init_calib_complete    DRAM calibration done (sampled only while calibrating)
//   i_cmd_* / o_cmd_ready    command: write flag, byte address, beats-1
//   i_wdata* / o_wdata_ready write beats (data, byte strobes)
//   o_rdata* / i_rdata_ready read beats, with last-beat flag
//   o_done, o_resp           one-cycle completion pulse and its AXI response
//   o_busy                   a command is being processed
//   s_axi_*                  AXI4 master AW/W/B/AR/R channels (all IDs driven as 0)
module dram_axi_burst_master #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 4,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned SIZE       = $clog2(STRB_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_x,
  input  logic                  i_init_calib_complete,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [7:0]            i_cmd_len,
  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [STRB_WIDTH-1:0] i_wstrb,
  output logic                  o_rdata_valid,
  input  logic                  i_rdata_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rdata_last,
  output logic                  o_done,
  output logic [1:0]            o_resp,
  output logic                  o_busy,
  output logic [ID_WIDTH-1:0]   s_axi_awid,
  output logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  output logic [7:0]            s_axi_awlen,
  output logic [2:0]            s_axi_awsize,
  output logic [1:0]            s_axi_awburst,
  output logic                  s_axi_awlock,
  output logic [3:0]            s_axi_awcache,
  output logic [2:0]            s_axi_awprot,
  output logic [3:0]            s_axi_awqos,
  output logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  output logic [DATA_WIDTH-1:0] s_axi_wdata,
  output logic [STRB_WIDTH-1:0] s_axi_wstrb,
  output logic                  s_axi_wlast,
  output logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [ID_WIDTH-1:0]   s_axi_bid,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bvalid,
  output logic                  s_axi_bready,
  output logic [ID_WIDTH-1:0]   s_axi_arid,
  output logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic [7:0]            s_axi_arlen,
  output logic [2:0]            s_axi_arsize,
  output logic [1:0]            s_axi_arburst,
  output logic                  s_axi_arlock,
  output logic [3:0]            s_axi_arcache,
  output logic [2:0]            s_axi_arprot,
  output logic [3:0]            s_axi_arqos,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [ID_WIDTH-1:0]   s_axi_rid,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rlast,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready
);

  typedef enum logic [2:0] {
    StCalib, StIdle, StReject, StWr, StWrResp, StRdAddr, StRdData, StRdDone
  } state_e;

  state_e                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic                  r_awvalid, r_arvalid;
  logic                  r_aw_done, r_w_done;
  logic [7:0]            r_wbeat;
  logic [8:0]            r_rbeat;
  logic [1:0]            r_rresp;

  logic                  w_cmd_fire, w_reject;
  logic [ADDR_WIDTH-1:0] w_bytes, w_end_addr;
  logic                  w_aw_fire, w_w_fire, w_w_last_fire, w_ar_fire, w_r_fire;
  logic [1:0]            w_rresp_max;
  logic                  w_unused;

  // Byte span of the burst; the last byte must sit in the same 4 KB page as the first.
  assign w_bytes    = ADDR_WIDTH'((32'(i_cmd_len) + 32'd1) << SIZE);
  assign w_end_addr = i_cmd_addr + w_bytes - ADDR_WIDTH'(1);
  assign w_reject   = (|i_cmd_addr[SIZE-1:0]) ||
                      (i_cmd_addr[ADDR_WIDTH-1:12] != w_end_addr[ADDR_WIDTH-1:12]);

  assign w_cmd_fire    = i_cmd_valid && (r_state == StIdle);
  assign w_aw_fire     = r_awvalid && s_axi_awready;
  assign w_w_fire      = s_axi_wvalid && s_axi_wready;
  assign w_w_last_fire = w_w_fire && (r_wbeat == r_len);
  assign w_ar_fire     = r_arvalid && s_axi_arready;
  assign w_r_fire      = (r_state == StRdData) && s_axi_rvalid && i_rdata_ready;
  assign w_rresp_max   = (s_axi_rresp > r_rresp) ? s_axi_rresp : r_rresp;
  assign w_unused      = ^{s_axi_bid, s_axi_rid};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StCalib:  if (i_init_calib_complete) w_state_next = StIdle;
      StIdle: begin
        if (i_cmd_valid) begin
          if (w_reject)         w_state_next = StReject;
          else if (i_cmd_write) w_state_next = StWr;
          else                  w_state_next = StRdAddr;
        end
      end
      StReject: w_state_next = StIdle;
      // AW and the last W beat may complete in either order or together.
      StWr:     if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_last_fire))
                  w_state_next = StWrResp;
      StWrResp: if (s_axi_bvalid) w_state_next = StIdle;
      StRdAddr: if (w_ar_fire) w_state_next = StRdData;
      StRdData: if (w_r_fire && s_axi_rlast) w_state_next = StRdDone;
      StRdDone: w_state_next = StIdle;
      default:  w_state_next = StCalib;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_x) begin
      r_state   <= StCalib;
      r_addr    <= '0;
      r_len     <= '0;
      r_awvalid <= 1'b0;
      r_arvalid <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_wbeat   <= '0;
      r_rbeat   <= '0;
      r_rresp   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cmd_fire) begin
        r_addr    <= i_cmd_addr;
        r_len     <= i_cmd_len;
        r_awvalid <= !w_reject && i_cmd_write;
        r_arvalid <= !w_reject && !i_cmd_write;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_wbeat   <= '0;
        r_rbeat   <= '0;
        r_rresp   <= '0;
      end
      if (w_aw_fire) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_fire) begin
        r_wbeat <= r_wbeat + 8'd1;
        if (r_wbeat == r_len) r_w_done <= 1'b1;
      end
      if (w_ar_fire) r_arvalid <= 1'b0;
      if (w_r_fire) begin
        r_rbeat <= r_rbeat + 9'd1;
        // rlast arriving on any beat other than len+1 is a protocol error.
        r_rresp <= (s_axi_rlast && (r_rbeat != {1'b0, r_len})) ? 2'b10 : w_rresp_max;
      end
    end
  end

  always_comb begin
    o_resp = 2'b00;
    case (r_state)
      StReject: o_resp = 2'b10;
      StWrResp: if (s_axi_bvalid) o_resp = s_axi_bresp;
      StRdDone: o_resp = r_rresp;
      default:  o_resp = 2'b00;
    endcase
  end

  assign o_cmd_ready   = (r_state == StIdle);
  assign o_busy        = (r_state != StIdle) && (r_state != StCalib);
  assign o_done        = (r_state == StReject) || (r_state == StRdDone) ||
                         ((r_state == StWrResp) && s_axi_bvalid);

  assign s_axi_wvalid  = (r_state == StWr) && !r_w_done && i_wdata_valid;
  assign o_wdata_ready = (r_state == StWr) && !r_w_done && s_axi_wready;
  assign s_axi_wdata   = i_wdata;
  assign s_axi_wstrb   = i_wstrb;
  assign s_axi_wlast   = (r_state == StWr) && (r_wbeat == r_len);
  assign s_axi_bready  = (r_state == StWrResp);

  assign o_rdata_valid = (r_state == StRdData) && s_axi_rvalid;
  assign s_axi_rready  = (r_state == StRdData) && i_rdata_ready;
  assign o_rdata       = s_axi_rdata;
  assign o_rdata_last  = (r_state == StRdData) && s_axi_rlast;

  assign s_axi_awid    = '0;
  assign s_axi_awaddr  = r_addr;
  assign s_axi_awlen   = r_len;
  assign s_axi_awsize  = 3'(SIZE);
  assign s_axi_awburst = 2'b01;
  assign s_axi_awlock  = 1'b0;
  assign s_axi_awcache = 4'b0000;
  assign s_axi_awprot  = 3'b000;
  assign s_axi_awqos   = 4'b0000;
  assign s_axi_awvalid = r_awvalid;

  assign s_axi_arid    = '0;
  assign s_axi_araddr  = r_addr;
  assign s_axi_arlen   = r_len;
  assign s_axi_arsize  = 3'(SIZE);
  assign s_axi_arburst = 2'b01;
  assign s_axi_arlock  = 1'b0;
  assign s_axi_arcache = 4'b0000;
  assign s_axi_arprot  = 3'b000;
  assign s_axi_arqos   = 4'b0000;
  assign s_axi_arvalid = r_arvalid;

endmodule

// File: tb/tb_dram_axi_burst_master.sv
// Directed bench for dram_axi_burst_master (ADDR 28, DATA 128, ID 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dram_axi_burst_master;
  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst_x, i_init_calib_complete;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [7:0]    i_cmd_len;
  logic          i_wdata_valid, o_wdata_ready;
  logic [DW-1:0] i_wdata;
  logic [SW-1:0] i_wstrb;
  logic          o_rdata_valid, i_rdata_ready, o_rdata_last, o_done, o_busy;
  logic [DW-1:0] o_rdata;
  logic [1:0]    o_resp;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, awprot, arsize, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock;
  logic [3:0]    awcache, awqos, arcache, arqos;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  int n_checks = 0;
  int n_errors = 0;

  dram_axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .i_clk(clk), .i_rst_x(i_rst_x), .i_init_calib_complete(i_init_calib_complete),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready),
    .o_rdata(o_rdata), .o_rdata_last(o_rdata_last), .o_done(o_done), .o_resp(o_resp),
    .o_busy(o_busy),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
    .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a command from a falling edge; returns one falling edge after acceptance.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                       output int waited);
    waited = -1;
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (o_cmd_ready) begin
        waited = i;
        break;
      end
      @(negedge clk);
    end
    check_val("cmd_accept", 128'(waited >= 0), 128'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [AW-1:0] addr, input logic [7:0] len,
                           input int aw_delay, input logic [1:0] b_resp, output int waited);
    int  wb = 0;
    int  beats_at_aw = -1;
    int  bad = 0;
    bit  aw_seen = 0;
    bit  done_seen = 0;
    logic [1:0] resp_seen = 2'b11;
    issue(1'b1, addr, len, waited);
    wready = 1'b1;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      i_wdata       = {4{32'hA000_0000 + 32'(wb)}};
      i_wstrb       = 16'hF0F0 ^ 16'(wb);
      i_wdata_valid = (wb <= int'(len));
      awready       = (k >= aw_delay);
      bvalid        = aw_seen && (wb > int'(len));
      bresp         = b_resp;
      #1;
      if (k == 0) check_val("wr_busy", 128'(o_busy), 128'd1);
      if (awvalid && awready && !aw_seen) begin
        aw_seen     = 1;
        beats_at_aw = wb;
        check_val("awaddr", 128'(awaddr), 128'(addr));
        check_val("aw_len_size_burst", {awlen, awsize, awburst}, {len, 3'd4, 2'b01});
      end
      if (wvalid && wready) begin
        if (wdata !== i_wdata || wstrb !== i_wstrb || wlast !== (wb == int'(len))) bad++;
        if (o_wdata_ready !== 1'b1) bad++;
        wb++;
      end
      if (o_done) begin
        done_seen = 1;
        resp_seen = o_resp;
        if (!(bvalid && bready)) bad++;
      end
      @(negedge clk);
    end
    bvalid = 1'b0; awready = 1'b0; i_wdata_valid = 1'b0;
    check_val("wr_beat_errors", 128'(bad), 128'd0);
    check_val("wr_beats", 128'(wb), 128'(int'(len) + 1));
    check_val("wr_beats_before_aw", 128'(beats_at_aw),
              128'((aw_delay < int'(len) + 1) ? aw_delay : int'(len) + 1));
    check_val("wr_done", 128'(done_seen), 128'd1);
    check_val("wr_resp", 128'(resp_seen), 128'(b_resp));
    #1;
    check_val("wr_idle_after", {o_cmd_ready, o_done, o_busy}, 3'b100);
    @(negedge clk);
  endtask

  // rlast_beat: beat index carrying rlast; err_beat: beat with rresp=2; rst_beat: reset there.
  task automatic run_read(input logic [AW-1:0] addr, input logic [7:0] len,
                          input int rlast_beat, input int err_beat, input int rst_beat,
                          input logic [1:0] exp_resp);
    int  w;
    int  rb = 0;
    int  bad = 0;
    bit  ar_seen = 0;
    bit  r_end = 0;
    bit  done_seen = 0;
    logic [1:0] resp_seen = 2'b11;
    issue(1'b0, addr, len, w);
    for (int k = 0; k < 80 && !done_seen; k++) begin
      arready       = 1'b1;
      rvalid        = ar_seen && (rb <= rlast_beat) && !r_end;
      rdata         = {96'h0, 32'hD000_0000 + 32'(rb)};
      rresp         = (rb == err_beat) ? 2'b10 : 2'b00;
      rlast         = (rb == rlast_beat);
      i_rdata_ready = k[0];
      if (rst_beat >= 0 && ar_seen && rb == rst_beat) begin
        i_rst_x = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_outputs",
                  {o_cmd_ready, o_busy, o_rdata_valid, rready, arvalid, awvalid, o_done,
                   o_resp}, 9'd0);
        i_rst_x = 1'b1;
        rvalid  = 1'b0;
        arready = 1'b0;
        @(negedge clk);
        return;
      end
      #1;
      if (arvalid && arready && !ar_seen) begin
        ar_seen = 1;
        check_val("araddr", 128'(araddr), 128'(addr));
        check_val("ar_len_size_burst", {arlen, arsize, arburst}, {len, 3'd4, 2'b01});
      end
      if (rvalid && rready) begin
        if (o_rdata_valid !== 1'b1) bad++;
        if (o_rdata !== {96'h0, 32'hD000_0000 + 32'(rb)}) bad++;
        if (o_rdata_last !== (rb == rlast_beat)) bad++;
        if (rb == rlast_beat) r_end = 1;
        rb++;
      end else if (rready !== i_rdata_ready && ar_seen && !r_end && rvalid) begin
        bad++;
      end
      if (o_done) begin
        done_seen = 1;
        resp_seen = o_resp;
        if (!r_end || (rvalid && rready)) bad++;
      end
      @(negedge clk);
    end
    rvalid = 1'b0; arready = 1'b0;
    check_val("rd_beat_errors", 128'(bad), 128'd0);
    check_val("rd_beats", 128'(rb), 128'(rlast_beat + 1));
    check_val("rd_done", 128'(done_seen), 128'd1);
    check_val("rd_resp", 128'(resp_seen), 128'(exp_resp));
    #1;
    check_val("rd_idle_after", {o_cmd_ready, o_done, rready}, 3'b100);
    @(negedge clk);
  endtask

  task automatic run_reject(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len);
    int w;
    issue(wr, addr, len, w);
    #1;
    check_val("rej_done_resp", {o_done, o_resp}, 3'b110);
    check_val("rej_no_axi", {awvalid, arvalid, wvalid}, 3'b000);
    @(negedge clk);
    #1;
    check_val("rej_idle", {o_cmd_ready, o_done, awvalid, arvalid}, 4'b1000);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit any_act;
    i_rst_x = 1'b0; i_init_calib_complete = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 28'h100; i_cmd_len = 8'd3;
    i_wdata_valid = 1'b0; i_wdata = '0; i_wstrb = '0; i_rdata_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_outputs",
              {o_cmd_ready, o_busy, o_done, o_resp, awvalid, arvalid, o_rdata_valid}, 8'd0);
    i_rst_x = 1'b1;

    // Calibration gating with a command already waiting.
    any_act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (o_cmd_ready || awvalid || arvalid || wvalid || o_busy) any_act = 1;
    end
    check_val("calib_gate", 128'(any_act), 128'd0);
    @(negedge clk);
    i_init_calib_complete = 1'b1;
    run_write(28'h100, 8'd3, 5, 2'b00, w);
    check_val("calib_accept_lat", 128'(w <= 1), 128'd1);

    // 8-beat read, toggling ready, error on beat 5.
    run_read(28'h2000, 8'd7, 7, 4, -1, 2'b10);

    // Address checks.
    run_reject(1'b1, 28'hFF0, 8'd1);
    run_reject(1'b0, 28'h104, 8'd0);
    run_write(28'hFE0, 8'd1, 0, 2'b01, w);

    // Reset during read beat 3, then a clean read.
    run_read(28'h3000, 8'd7, 7, -1, 2, 2'b00);
    run_read(28'h4000, 8'd3, 3, -1, -1, 2'b00);

    // Slave ends a 4-beat read after 2 beats.
    run_read(28'h5000, 8'd3, 1, -1, -1, 2'b10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
